// File: rtl/msu_pkg.sv
// Command/status codes and scheduler state shared by the MSU-1 command path.
package msu_pkg;

   localparam int unsigned CMD_W  = 48;
   localparam int unsigned CODE_W = 16;
   localparam int unsigned TRK_W  = 16;
   localparam int unsigned SEC_W  = 32;

   localparam logic [CODE_W-1:0] CMD_SECTOR = 16'h0034;
   localparam logic [CODE_W-1:0] CMD_TRACK  = 16'h0035;
   localparam logic [CODE_W-1:0] CMD_JUMP   = 16'h0036;
   localparam logic [CODE_W-1:0] CMD_RESET  = 16'h00FF;

   localparam logic [CODE_W-1:0] ST_MOUNTED = 16'h0201;
   localparam logic [CODE_W-1:0] ST_MISSING = 16'h0401;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_MOUNT = 2'd2
   } sched_state_e;

   // Command word: 32-bit argument above the 16-bit opcode.
   function automatic logic [CMD_W-1:0] mk_cmd(input logic [SEC_W-1:0] arg,
                                                input logic [CODE_W-1:0] code);
      return {arg, code};
   endfunction

endpackage

// File: rtl/msu_req_capture.sv
// One requester slot: rising-edge detect, pending flag and operand latch.
module msu_req_capture
   import msu_pkg::*;
#(
   parameter int unsigned W = 1
) (
   input  logic         clk_sys,
   input  logic         reset,
   input  logic         req,
   input  logic         gate,
   input  logic         clr,
   input  logic         sup,
   input  logic [W-1:0] opnd_in,
   output logic         rise_c,
   output logic         pend,
   output logic [W-1:0] opnd
);

   logic         req_q,  req_d;
   logic         pend_q, pend_d;
   logic [W-1:0] opnd_q, opnd_d;

   assign rise_c = req & ~req_q & ~gate;

   // A fresh edge beats the issue-clear; a supersede beats everything.
   always_comb begin
      req_d  = req;
      pend_d = pend_q;
      opnd_d = opnd_q;
      if (clr) begin
         pend_d = 1'b0;
      end
      if (rise_c) begin
         pend_d = 1'b1;
         opnd_d = opnd_in;
      end
      if (sup) begin
         pend_d = 1'b0;
      end
   end

   // Edge detector tracks the live level during reset so release makes no edge.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         req_q  <= req;
         pend_q <= 1'b0;
         opnd_q <= '0;
      end else begin
         req_q  <= req_d;
         pend_q <= pend_d;
         opnd_q <= opnd_d;
      end
   end

   assign pend = pend_q;
   assign opnd = opnd_q;

endmodule

// File: rtl/msu_cmd_sched.sv
// MSU-1 command scheduler: captures core requests, issues one command at a time to HPS.
// Optional mount watchdog enabled by defining MSU_MOUNT_TIMEOUT_EN.
module msu_cmd_sched
   import msu_pkg::*;
`ifdef MSU_MOUNT_TIMEOUT_EN
#(
   parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
)
`endif
(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        trackrequest,
   input  logic [15:0] trackout,
   input  logic        jump_sector,
   input  logic [31:0] sector,
   input  logic        audio_req,
   output logic        cmd_valid,
   output logic [47:0] cmd_data,
   input  logic        cmd_ready,
   input  logic        status_valid,
   input  logic [15:0] status_code,
   output logic        trackmounting,
   output logic        trackmissing,
   output logic        busy
);

   sched_state_e     state_q, state_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [CMD_W-1:0] cmd_data_q, cmd_data_d;
   logic             mounting_q, mounting_d;
   logic             missing_q, missing_d;

   logic             rst_pend, trk_pend, jmp_pend, sec_pend;
   logic             clr_rst, clr_trk, clr_jmp, clr_sec;
   logic             trk_rise_c;
   logic [2:0]       rise_unused;
   logic             rst_opnd_unused, sec_opnd_unused;
   logic [TRK_W-1:0] trk_opnd;
   logic [SEC_W-1:0] jmp_opnd;
   logic             audio_gate_c;
   logic             status_hit_c;

`ifdef MSU_MOUNT_TIMEOUT_EN
   logic [23:0]      cnt_q, cnt_d;
`endif

   assign audio_gate_c = mounting_q | missing_q;

   // Reset-notify is the rising edge of "out of reset".
   msu_req_capture #(.W(1)) u_rst (
      .clk_sys (clk_sys),
      .reset   (reset),
      .req     (~reset),
      .gate    (1'b0),
      .clr     (clr_rst),
      .sup     (1'b0),
      .opnd_in (1'b0),
      .rise_c  (rise_unused[0]),
      .pend    (rst_pend),
      .opnd    (rst_opnd_unused)
   );

   msu_req_capture #(.W(TRK_W)) u_trk (
      .clk_sys (clk_sys),
      .reset   (reset),
      .req     (trackrequest),
      .gate    (1'b0),
      .clr     (clr_trk),
      .sup     (1'b0),
      .opnd_in (trackout),
      .rise_c  (trk_rise_c),
      .pend    (trk_pend),
      .opnd    (trk_opnd)
   );

   // A new track request makes any queued seek or sector fetch stale.
   msu_req_capture #(.W(SEC_W)) u_jmp (
      .clk_sys (clk_sys),
      .reset   (reset),
      .req     (jump_sector),
      .gate    (1'b0),
      .clr     (clr_jmp),
      .sup     (trk_rise_c),
      .opnd_in (sector),
      .rise_c  (rise_unused[1]),
      .pend    (jmp_pend),
      .opnd    (jmp_opnd)
   );

   msu_req_capture #(.W(1)) u_sec (
      .clk_sys (clk_sys),
      .reset   (reset),
      .req     (audio_req),
      .gate    (audio_gate_c),
      .clr     (clr_sec),
      .sup     (trk_rise_c),
      .opnd_in (1'b0),
      .rise_c  (rise_unused[2]),
      .pend    (sec_pend),
      .opnd    (sec_opnd_unused)
   );

   assign status_hit_c = status_valid &
                         ((status_code == ST_MOUNTED) || (status_code == ST_MISSING));

   // Next-state, command load and mount flag tracking.
   always_comb begin
      state_d     = state_q;
      cmd_valid_d = cmd_valid_q;
      cmd_data_d  = cmd_data_q;
      mounting_d  = mounting_q;
      missing_d   = missing_q;
      clr_rst     = 1'b0;
      clr_trk     = 1'b0;
      clr_jmp     = 1'b0;
      clr_sec     = 1'b0;
`ifdef MSU_MOUNT_TIMEOUT_EN
      cnt_d       = 24'd0;
`endif

      if (status_valid && (status_code == ST_MOUNTED)) begin
         mounting_d = 1'b0;
         missing_d  = 1'b0;
      end else if (status_valid && (status_code == ST_MISSING)) begin
         mounting_d = 1'b0;
         missing_d  = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (rst_pend) begin
               cmd_data_d  = mk_cmd('0, CMD_RESET);
               clr_rst     = 1'b1;
               cmd_valid_d = 1'b1;
               state_d     = S_ISSUE;
            end else if (trk_pend) begin
               cmd_data_d  = mk_cmd(SEC_W'(trk_opnd), CMD_TRACK);
               clr_trk     = 1'b1;
               cmd_valid_d = 1'b1;
               mounting_d  = 1'b1;
               missing_d   = 1'b0;
               state_d     = S_ISSUE;
            end else if (jmp_pend) begin
               cmd_data_d  = mk_cmd(jmp_opnd, CMD_JUMP);
               clr_jmp     = 1'b1;
               cmd_valid_d = 1'b1;
               state_d     = S_ISSUE;
            end else if (sec_pend) begin
               cmd_data_d  = mk_cmd('0, CMD_SECTOR);
               clr_sec     = 1'b1;
               cmd_valid_d = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = (cmd_data_q[CODE_W-1:0] == CMD_TRACK) ? S_MOUNT : S_IDLE;
            end
         end
         S_MOUNT: begin
            if (status_hit_c) begin
               state_d = S_IDLE;
`ifdef MSU_MOUNT_TIMEOUT_EN
            end else if (cnt_q == (TIMEOUT_CYC - 24'd1)) begin
               mounting_d = 1'b0;
               missing_d  = 1'b1;
               state_d    = S_IDLE;
            end else begin
               cnt_d = cnt_q + 24'd1;
`endif
            end
         end
         default: begin
            state_d     = S_IDLE;
            cmd_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cmd_valid_q <= 1'b0;
         cmd_data_q  <= '0;
         mounting_q  <= 1'b0;
         missing_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_data_q  <= cmd_data_d;
         mounting_q  <= mounting_d;
         missing_q   <= missing_d;
      end
   end

`ifdef MSU_MOUNT_TIMEOUT_EN
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt_q <= 24'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // Valid is masked by reset so an in-flight command cannot complete during reset.
   assign cmd_valid     = cmd_valid_q & ~reset;
   assign cmd_data      = cmd_data_q;
   assign trackmounting = mounting_q;
   assign trackmissing  = missing_q;
   assign busy          = ~reset & (cmd_valid_q | rst_pend | trk_pend | jmp_pend | sec_pend);

endmodule

// File: tb/tb_msu_cmd_sched.sv
// Directed + randomized bench for msu_cmd_sched with a transaction-level reference model.
module tb_msu_cmd_sched;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        trackrequest = 1'b0;
   logic [15:0] trackout = '0;
   logic        jump_sector = 1'b0;
   logic [31:0] sector = '0;
   logic        audio_req = 1'b0;
   logic        cmd_valid;
   logic [47:0] cmd_data;
   logic        cmd_ready = 1'b0;
   logic        status_valid = 1'b0;
   logic [15:0] status_code = '0;
   logic        trackmounting, trackmissing, busy;

   int n_pass = 0;
   int n_chk  = 0;

   // Reference model state: the two mount flags as the HPS protocol defines them.
   bit m_mounting = 1'b0;
   bit m_missing  = 1'b0;

   always #5 clk_sys = ~clk_sys;

`ifdef MSU_MOUNT_TIMEOUT_EN
   msu_cmd_sched #(.TIMEOUT_CYC(24'd100)) dut (
`else
   msu_cmd_sched dut (
`endif
      .clk_sys       (clk_sys),
      .reset         (reset),
      .trackrequest  (trackrequest),
      .trackout      (trackout),
      .jump_sector   (jump_sector),
      .sector        (sector),
      .audio_req     (audio_req),
      .cmd_valid     (cmd_valid),
      .cmd_data      (cmd_data),
      .cmd_ready     (cmd_ready),
      .status_valid  (status_valid),
      .status_code   (status_code),
      .trackmounting (trackmounting),
      .trackmissing  (trackmissing),
      .busy          (busy)
   );

   function automatic logic [47:0] exp_track(input logic [15:0] t);
      return {16'h0000, t, 16'h0035};
   endfunction

   function automatic logic [47:0] exp_jump(input logic [31:0] s);
      return {s, 16'h0036};
   endfunction

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, "_mounting"}, trackmounting, m_mounting);
      chk({tag, "_missing"},  trackmissing,  m_missing);
   endtask

   // Wait for one command, stalling ready randomly, and check it end to end.
   task automatic expect_cmd(input string tag, input logic [47:0] exp, input int unsigned stall);
      logic [47:0] first;
      bit seen, stable, got;
      first  = '0;
      seen   = 1'b0;
      stable = 1'b1;
      got    = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (cmd_valid) begin
            if (!seen) begin
               first = cmd_data;
               seen  = 1'b1;
            end else if (cmd_data !== first) begin
               stable = 1'b0;
            end
            cmd_ready = ($urandom_range(0, stall) == 0);
            if (cmd_ready) got = 1'b1;
         end
         @(negedge clk_sys);
      end
      cmd_ready = 1'b0;
      chk({tag, "_handshake"}, 48'(got), 48'd1);
      chk({tag, "_data"}, first, exp);
      chk({tag, "_stable"}, 48'(stable), 48'd1);
      chk({tag, "_drop"}, 48'(cmd_valid), 48'd0);
   endtask

   task automatic expect_none(input string tag, input int n);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (cmd_valid) seen = 1'b1;
         @(negedge clk_sys);
      end
      chk(tag, 48'(seen), 48'd0);
   endtask

   task automatic send_status(input string tag, input logic [15:0] code);
      status_valid = 1'b1;
      status_code  = code;
      @(negedge clk_sys);
      status_valid = 1'b0;
      if (code == 16'h0201) begin
         m_mounting = 1'b0;
         m_missing  = 1'b0;
      end else if (code == 16'h0401) begin
         m_mounting = 1'b0;
         m_missing  = 1'b1;
      end
      chk_flags(tag);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 10 && !cmd_valid; i++) @(negedge clk_sys);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2:0]  mask;
      logic [15:0] t;
      logic [31:0] s;
      bit          sec_ok;

      // Reset state
      repeat (3) @(negedge clk_sys);
      chk("rst_valid", 48'(cmd_valid), 48'd0);
      chk("rst_data", cmd_data, 48'd0);
      chk("rst_busy", 48'(busy), 48'd0);
      chk_flags("rst");
      reset = 1'b0;
      expect_cmd("rst_notify", 48'h0000_0000_00FF, 0);
      expect_none("rst_single", 6);
      chk("rst_busy_after", 48'(busy), 48'd0);

      // Track 7 with N+2 latency, then mounted
      trackout     = 16'h0007;
      trackrequest = 1'b1;
      @(negedge clk_sys);
      trackrequest = 1'b0;
      chk("lat_n1_valid", 48'(cmd_valid), 48'd0);
      @(negedge clk_sys);
      chk("lat_n2_valid", 48'(cmd_valid), 48'd1);
      chk("trk7_mounting_issue", 48'(trackmounting), 48'd1);
      expect_cmd("trk7", 48'h0000_0007_0035, 0);
      m_mounting = 1'b1;
      m_missing  = 1'b0;
      chk_flags("trk7_mount");
      expect_none("trk7_wait", 4);
      send_status("trk7_st201", 16'h0201);
      chk("trk7_busy", 48'(busy), 48'd0);

      // Simultaneous edges: track supersedes jump and sector
      trackout     = 16'h0009;
      sector       = 32'h0000_BEEF;
      trackrequest = 1'b1;
      jump_sector  = 1'b1;
      audio_req    = 1'b1;
      @(negedge clk_sys);
      trackrequest = 1'b0;
      jump_sector  = 1'b0;
      audio_req    = 1'b0;
      expect_cmd("simul_trk", exp_track(16'h0009), 1);
      m_mounting = 1'b1;
      m_missing  = 1'b0;
      send_status("simul_st201", 16'h0201);
      expect_none("simul_dropped", 8);

      // Jump held for 5 cycles of backpressure
      sector      = 32'h0000_1234;
      jump_sector = 1'b1;
      @(negedge clk_sys);
      jump_sector = 1'b0;
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 48'(cmd_valid), 48'd1);
         chk("hold_data", cmd_data, 48'h0000_1234_0036);
         @(negedge clk_sys);
      end
      expect_cmd("hold_jmp", 48'h0000_1234_0036, 0);

      // Track then missing: audio requests are ignored
      trackout     = 16'h0003;
      trackrequest = 1'b1;
      @(negedge clk_sys);
      trackrequest = 1'b0;
      expect_cmd("trk3", exp_track(16'h0003), 0);
      m_mounting = 1'b1;
      m_missing  = 1'b0;
      send_status("trk3_st401", 16'h0401);
      audio_req = 1'b1;
      @(negedge clk_sys);
      audio_req = 1'b0;
      expect_none("missing_gate", 8);

      // Reset while a command is waiting for ready
      sector      = 32'h0000_0055;
      jump_sector = 1'b1;
      @(negedge clk_sys);
      jump_sector = 1'b0;
      wait_valid();
      reset = 1'b1;
      #1;
      chk("rst_mid_drop", 48'(cmd_valid), 48'd0);
      @(negedge clk_sys);
      @(negedge clk_sys);
      reset      = 1'b0;
      m_mounting = 1'b0;
      m_missing  = 1'b0;
      chk_flags("rst_mid");
      expect_cmd("rst_mid_notify", 48'h0000_0000_00FF, 1);
      expect_none("rst_mid_discard", 6);

      // Randomized request bursts against the model
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 2))
               0:       send_status("rnd_idle_st", 16'h0201);
               1:       send_status("rnd_idle_st", 16'h0401);
               default: send_status("rnd_idle_st", 16'h0123);
            endcase
         end
         mask         = 3'($urandom_range(1, 7));
         t            = 16'($urandom);
         s            = $urandom;
         sec_ok       = !(m_mounting || m_missing);
         trackout     = t;
         sector       = s;
         trackrequest = mask[2];
         jump_sector  = mask[1];
         audio_req    = mask[0];
         @(negedge clk_sys);
         trackrequest = 1'b0;
         jump_sector  = 1'b0;
         audio_req    = 1'b0;
         if (mask[2]) begin
            expect_cmd("rnd_trk", exp_track(t), 3);
            m_mounting = 1'b1;
            m_missing  = 1'b0;
            chk_flags("rnd_trk_mount");
            if ($urandom_range(0, 1) == 0) send_status("rnd_junk", 16'h0123);
            if ($urandom_range(0, 1) == 0) send_status("rnd_st", 16'h0201);
            else                           send_status("rnd_st", 16'h0401);
         end else begin
            if (mask[1]) expect_cmd("rnd_jmp", exp_jump(s), 3);
            if (mask[0] && sec_ok) expect_cmd("rnd_sec", 48'h0000_0000_0034, 3);
         end
         expect_none("rnd_idle", 3);
      end

`ifdef MSU_MOUNT_TIMEOUT_EN
      // Watchdog: missing asserts 100 cycles after entering MOUNT
      trackout     = 16'h0011;
      trackrequest = 1'b1;
      @(negedge clk_sys);
      trackrequest = 1'b0;
      expect_cmd("to_trk", exp_track(16'h0011), 0);
      for (int n = 1; n <= 101; n++) begin
         if (n == 100) chk("to_before", 48'(trackmissing), 48'd0);
         if (n == 101) chk("to_at", 48'(trackmissing), 48'd1);
         if (n < 101) @(negedge clk_sys);
      end
      m_mounting = 1'b0;
      m_missing  = 1'b1;
      chk_flags("to_flags");
      send_status("to_late_st", 16'h0201);
      expect_none("to_idle", 4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
